prod_sched: RTL and testbench
=============================

// Module: prod_sched
// PURPOSE
//   Sequencing controller for the two data producers (Fibonacci, Timer) feeding
//   the buffer wrapper. It takes the edge-detected start/stop pulses, selects the
//   active producer and gates its enable. It muxes the producer word onto the
//   buffer write port, throttles on buffer_full and drains the buffer on stop.
//   It drives the state LEDs and the modulo select for the display module.
// PARAMETERS
//   DATA_W         16     width of producer words and buffer write data
//   DRAIN_TIMEOUT  4096   max clk cycles in S_BUF_EMPTY before forced return to S_IDLE
// PORTS
//   clk           in   1       system clock, 100 MHz; every input is synchronous to it
//   rst           in   1       asynchronous reset, active high
//   start_f_ed    in   1       1-cycle pulse: start/continue Fibonacci
//   start_t_ed    in   1       1-cycle pulse: start/continue Timer
//   stop_f_t_ed   in   1       1-cycle pulse: stop production, drain buffer
//   buffer_full   in   1       buffer wrapper full flag
//   buffer_empty  in   1       buffer wrapper empty flag
//   data_2_valid  in   1       consumer side still presenting a word
//   f_valid       in   1       Fibonacci word valid
//   f_out         in   DATA_W  Fibonacci word
//   t_valid       in   1       Timer word valid
//   t_out         in   DATA_W  Timer word
//   f_en          out  1       Fibonacci enable
//   t_en          out  1       Timer enable
//   data_1_en     out  1       buffer write strobe
//   data_1        out  DATA_W  buffer write data
//   modulo        out  2       active source: 00 none, 01 Fibonacci, 10 Timer
//   led           out  6       one-hot state indicator
//   wr_count      out  16      words written in the current run
//   drain_err     out  1       sticky: drain timed out
// BEHAVIOUR
//   States, one-hot on led: [0] S_IDLE, [1] S_COMM_F, [2] S_WAIT_F, [3] S_COMM_T,
//     [4] S_WAIT_T, [5] S_BUF_EMPTY.
//   Reset: state S_IDLE, led=6'b000001, f_en=t_en=data_1_en=0, data_1=0,
//     modulo=00, wr_count=0, drain_err=0, drain counter=0.
//   Transitions (evaluated each clk; listed in priority order):
//     S_IDLE:      start_f_ed -> S_COMM_F; else start_t_ed -> S_COMM_T
//                  (both pulses in the same cycle: Fibonacci wins).
//     S_COMM_F/T:  stop_f_t_ed -> S_BUF_EMPTY; else buffer_full -> S_WAIT_F/T.
//     S_WAIT_F/T:  stop_f_t_ed -> S_BUF_EMPTY; else !buffer_full -> S_COMM_F/T.
//     S_BUF_EMPTY: buffer_empty && !data_2_valid -> S_IDLE; else drain counter
//                  == DRAIN_TIMEOUT-1 -> S_IDLE and set drain_err.
//   Start pulses outside S_IDLE are ignored; switching source requires stop then drain.
//   f_en = (state==S_COMM_F); t_en = (state==S_COMM_T). Both are Moore outputs
//     decoded from the state register and are never high together.
//   Write path, 1-cycle registered latency: in S_COMM_F with f_valid && !buffer_full
//     && !stop_f_t_ed, the next cycle has data_1_en=1 and data_1=f_out. Same for
//     Timer with t_valid/t_out. Otherwise data_1_en=0 and data_1 holds its value.
//   No write is issued in S_WAIT_*, S_BUF_EMPTY or S_IDLE. A stop pulse in the same
//     cycle as a valid word drops that word.
//   modulo: loads 01/10 on entry to S_COMM_F/S_COMM_T from S_IDLE. It holds through
//     WAIT and BUF_EMPTY so the display shows the last source, and clears to 00 on
//     return to S_IDLE.
//   wr_count: clears to 0 on S_IDLE->COMM transition and +1 per data_1_en.
//     It wraps 0xFFFF->0x0000 and holds in S_IDLE.
//   Drain counter: zeroed on entry to S_BUF_EMPTY and +1 per cycle there.
//     drain_err clears only on rst or on the next S_IDLE->COMM transition.
//   rst mid-operation: state and all outputs return to reset values asynchronously.
//     Any in-flight data_1_en is dropped.
// TESTING
//   1. rst, start_f_ed pulse, f_valid every 4 cycles with f_out=1,1,2,3 ->
//      led=000010, f_en=1, four data_1_en pulses one cycle after each valid,
//      data_1=1,1,2,3, wr_count=4, modulo=01.
//   2. COMM_T, raise buffer_full with t_valid=1 -> next cycle S_WAIT_T (led=010000),
//      t_en=0, no data_1_en. Drop buffer_full -> S_COMM_T one cycle later, writes resume.
//   3. start_f_ed and start_t_ed in the same cycle in S_IDLE -> S_COMM_F, modulo=01.
//      Later start_t_ed during S_COMM_F -> ignored, state unchanged.
//   4. stop_f_t_ed coincident with f_valid in S_COMM_F -> S_BUF_EMPTY, that word not
//      written. Hold buffer_empty=1, data_2_valid=0 -> S_IDLE next cycle, modulo=00.
//   5. DRAIN_TIMEOUT=8, S_BUF_EMPTY with buffer_empty=0 -> exactly 8 cycles later
//      S_IDLE, drain_err=1 and stays 1 until next start_f_ed.
//   6. Assert rst during S_WAIT_F with data_1_en pending -> same cycle led=000001,
//      data_1_en=0, wr_count=0, f_en=0.

Source files
------------

// File: rtl/prod_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : prod_sched_if
// Description : Bundle of producer, buffer and display signals seen by the
//               producer sequencing controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface prod_sched_if #(
  parameter int DATA_W = 16
);
  // Control pulses and buffer status
  logic              start_f_ed;
  logic              start_t_ed;
  logic              stop_f_t_ed;
  logic              buffer_full;
  logic              buffer_empty;
  logic              data_2_valid;
  // Producer words
  logic              f_valid;
  logic [DATA_W-1:0] f_out;
  logic              t_valid;
  logic [DATA_W-1:0] t_out;
  // Controller outputs
  logic              f_en;
  logic              t_en;
  logic              data_1_en;
  logic [DATA_W-1:0] data_1;
  logic [1:0]        modulo;
  logic [5:0]        led;
  logic [15:0]       wr_count;
  logic              drain_err;

  // Controller side
  modport master (
    input  start_f_ed, start_t_ed, stop_f_t_ed, buffer_full, buffer_empty,
           data_2_valid, f_valid, f_out, t_valid, t_out,
    output f_en, t_en, data_1_en, data_1, modulo, led, wr_count, drain_err
  );

  // Producers, buffer and display side
  modport slave (
    output start_f_ed, start_t_ed, stop_f_t_ed, buffer_full, buffer_empty,
           data_2_valid, f_valid, f_out, t_valid, t_out,
    input  f_en, t_en, data_1_en, data_1, modulo, led, wr_count, drain_err
  );
endinterface
`default_nettype wire

// File: rtl/prod_sched.sv
`default_nettype none
// ============================================================================
// Module      : prod_sched
// Description : Sequencing controller for the Fibonacci and Timer producers.
//               Selects the active source, gates its enable, registers its
//               words onto the buffer write port, throttles on buffer full
//               and drains the buffer after a stop.
// Revision    : 1.0 - initial release
// ============================================================================
module prod_sched #(
  parameter int DATA_W        = 16,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  wire logic    clk,
  input  wire logic    rst,
  prod_sched_if.master bus_if
);

  localparam int         c_CNT_W      = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam logic [c_CNT_W-1:0] c_DRAIN_LAST = c_CNT_W'(DRAIN_TIMEOUT - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_COMM_F    = 3'd1;
  localparam logic [2:0] S_WAIT_F    = 3'd2;
  localparam logic [2:0] S_COMM_T    = 3'd3;
  localparam logic [2:0] S_WAIT_T    = 3'd4;
  localparam logic [2:0] S_BUF_EMPTY = 3'd5;

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic               w_timeout;
  logic               w_start_run;
  logic               w_to_idle;
  logic               w_wr_req;
  logic [DATA_W-1:0]  w_wr_data;
  logic [5:0]         w_led;
  logic               w_f_en;
  logic               w_t_en;

  logic               r_data_1_en;
  logic [DATA_W-1:0]  r_data_1;
  logic [1:0]         r_modulo;
  logic [15:0]        r_wr_count;
  logic [c_CNT_W-1:0] r_drain_cnt;
  logic               r_drain_err;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a clean drain wins over the timeout in the same cycle
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus_if.start_f_ed)      w_state_nxt = S_COMM_F;
        else if (bus_if.start_t_ed) w_state_nxt = S_COMM_T;
      end
      S_COMM_F: begin
        if (bus_if.stop_f_t_ed)      w_state_nxt = S_BUF_EMPTY;
        else if (bus_if.buffer_full) w_state_nxt = S_WAIT_F;
      end
      S_WAIT_F: begin
        if (bus_if.stop_f_t_ed)       w_state_nxt = S_BUF_EMPTY;
        else if (!bus_if.buffer_full) w_state_nxt = S_COMM_F;
      end
      S_COMM_T: begin
        if (bus_if.stop_f_t_ed)      w_state_nxt = S_BUF_EMPTY;
        else if (bus_if.buffer_full) w_state_nxt = S_WAIT_T;
      end
      S_WAIT_T: begin
        if (bus_if.stop_f_t_ed)       w_state_nxt = S_BUF_EMPTY;
        else if (!bus_if.buffer_full) w_state_nxt = S_COMM_T;
      end
      S_BUF_EMPTY: begin
        if (bus_if.buffer_empty && !bus_if.data_2_valid) begin
          w_state_nxt = S_IDLE;
        end else if (r_drain_cnt == c_DRAIN_LAST) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Moore decodes plus the write request for the word on the producer bus
  always_comb begin
    w_led       = 6'b000000;
    w_f_en      = 1'b0;
    w_t_en      = 1'b0;
    w_wr_req    = 1'b0;
    w_wr_data   = bus_if.f_out;
    w_start_run = (r_state == S_IDLE) &&
                  ((w_state_nxt == S_COMM_F) || (w_state_nxt == S_COMM_T));
    w_to_idle   = (r_state != S_IDLE) && (w_state_nxt == S_IDLE);
    case (r_state)
      S_IDLE:      w_led = 6'b000001;
      S_COMM_F: begin
        w_led     = 6'b000010;
        w_f_en    = 1'b1;
        w_wr_req  = bus_if.f_valid && !bus_if.buffer_full && !bus_if.stop_f_t_ed;
        w_wr_data = bus_if.f_out;
      end
      S_WAIT_F:    w_led = 6'b000100;
      S_COMM_T: begin
        w_led     = 6'b001000;
        w_t_en    = 1'b1;
        w_wr_req  = bus_if.t_valid && !bus_if.buffer_full && !bus_if.stop_f_t_ed;
        w_wr_data = bus_if.t_out;
      end
      S_WAIT_T:    w_led = 6'b010000;
      S_BUF_EMPTY: w_led = 6'b100000;
      default:     w_led = 6'b000000;
    endcase
  end

  // Registered write port; data holds between strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data_1_en <= 1'b0;
      r_data_1    <= '0;
    end else begin
      r_data_1_en <= w_wr_req;
      if (w_wr_req) r_data_1 <= w_wr_data;
    end
  end

  // Source select: set when a run starts, kept through drain, cleared back in idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_modulo <= 2'b00;
    end else if (w_start_run) begin
      r_modulo <= (w_state_nxt == S_COMM_F) ? 2'b01 : 2'b10;
    end else if (w_to_idle) begin
      r_modulo <= 2'b00;
    end
  end

  // Per-run write counter, free-wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              r_wr_count <= '0;
    else if (w_start_run) r_wr_count <= '0;
    else if (r_data_1_en) r_wr_count <= r_wr_count + 16'd1;
  end

  // Drain watchdog and its sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drain_cnt <= '0;
      r_drain_err <= 1'b0;
    end else begin
      if ((w_state_nxt == S_BUF_EMPTY) && (r_state != S_BUF_EMPTY))
        r_drain_cnt <= '0;
      else if (r_state == S_BUF_EMPTY)
        r_drain_cnt <= r_drain_cnt + 1'b1;

      if (w_timeout)        r_drain_err <= 1'b1;
      else if (w_start_run) r_drain_err <= 1'b0;
    end
  end

  assign bus_if.f_en      = w_f_en;
  assign bus_if.t_en      = w_t_en;
  assign bus_if.led       = w_led;
  assign bus_if.data_1_en = r_data_1_en;
  assign bus_if.data_1    = r_data_1;
  assign bus_if.modulo    = r_modulo;
  assign bus_if.wr_count  = r_wr_count;
  assign bus_if.drain_err = r_drain_err;

endmodule
`default_nettype wire

// File: tb/tb_prod_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_prod_sched
// Description : Self-checking bench for prod_sched with a write-data scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prod_sched;

  localparam int DATA_W = 16;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [DATA_W-1:0] exp_q[$];

  prod_sched_if #(.DATA_W(DATA_W)) bus();

  prod_sched #(.DATA_W(DATA_W), .DRAIN_TIMEOUT(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every write strobe must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && bus.data_1_en === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected_write: got data_1=%h, required no write", bus.data_1);
      end else begin
        logic [DATA_W-1:0] exp_w;
        exp_w = exp_q.pop_front();
        if (bus.data_1 !== exp_w) begin
          n_err++;
          $display("FAIL sb_data_1: got %h, required %h", bus.data_1, exp_w);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input bit fib);
    if (fib) bus.start_f_ed = 1'b1;
    else     bus.start_t_ed = 1'b1;
    tick();
    bus.start_f_ed = 1'b0;
    bus.start_t_ed = 1'b0;
  endtask

  task automatic go_idle();
    bus.stop_f_t_ed = 1'b1;
    tick();
    bus.stop_f_t_ed = 1'b0;
    n_vec++;
    if (bus.led !== 6'b100000) begin
      n_err++;
      $display("FAIL drain_led: got %b, required 100000", bus.led);
    end
    bus.buffer_empty = 1'b1;
    tick();
    bus.buffer_empty = 1'b0;
    n_vec++;
    if (bus.led !== 6'b000001 || bus.modulo !== 2'b00) begin
      n_err++;
      $display("FAIL idle_return: got led=%b modulo=%b, required 000001/00", bus.led, bus.modulo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if (bus.led !== 6'b000001 || bus.f_en !== 1'b0 || bus.t_en !== 1'b0 ||
        bus.data_1_en !== 1'b0 || bus.data_1 !== 16'h0 || bus.modulo !== 2'b00 ||
        bus.wr_count !== 16'h0 || bus.drain_err !== 1'b0) begin
      n_err++;
      $display("FAIL reset: got led=%b f_en=%b t_en=%b en=%b d=%h mod=%b cnt=%h err=%b, required 000001/0/0/0/0000/00/0000/0",
               bus.led, bus.f_en, bus.t_en, bus.data_1_en, bus.data_1, bus.modulo,
               bus.wr_count, bus.drain_err);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fib_run();
    logic [DATA_W-1:0] fib_words [4];
    fib_words = '{16'd1, 16'd1, 16'd2, 16'd3};
    start_run(1'b1);
    n_vec++;
    if (bus.led !== 6'b000010 || bus.f_en !== 1'b1 || bus.t_en !== 1'b0 || bus.modulo !== 2'b01) begin
      n_err++;
      $display("FAIL fib_enter: got led=%b f_en=%b t_en=%b mod=%b, required 000010/1/0/01",
               bus.led, bus.f_en, bus.t_en, bus.modulo);
    end
    for (int i = 0; i < 4; i++) begin
      bus.f_valid = 1'b1;
      bus.f_out   = fib_words[i];
      exp_q.push_back(fib_words[i]);
      tick();
      bus.f_valid = 1'b0;
      n_vec++;
      if (bus.data_1_en !== 1'b1 || bus.data_1 !== fib_words[i]) begin
        n_err++;
        $display("FAIL fib_write%0d: got en=%b d=%h, required 1/%h", i, bus.data_1_en, bus.data_1, fib_words[i]);
      end
      for (int j = 0; j < 3; j++) tick();
    end
    n_vec++;
    if (bus.wr_count !== 16'd4 || bus.modulo !== 2'b01) begin
      n_err++;
      $display("FAIL fib_count: got cnt=%0d mod=%b, required 4/01", bus.wr_count, bus.modulo);
    end
    go_idle();
  endtask

  task automatic test_throttle();
    start_run(1'b0);
    n_vec++;
    if (bus.led !== 6'b001000 || bus.t_en !== 1'b1 || bus.modulo !== 2'b10) begin
      n_err++;
      $display("FAIL tim_enter: got led=%b t_en=%b mod=%b, required 001000/1/10", bus.led, bus.t_en, bus.modulo);
    end
    bus.t_valid     = 1'b1;
    bus.t_out       = 16'h0055;
    bus.buffer_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.led !== 6'b010000 || bus.t_en !== 1'b0 || bus.data_1_en !== 1'b0) begin
        n_err++;
        $display("FAIL tim_wait%0d: got led=%b t_en=%b en=%b, required 010000/0/0", i, bus.led, bus.t_en, bus.data_1_en);
      end
    end
    bus.buffer_full = 1'b0;
    tick();
    n_vec++;
    if (bus.led !== 6'b001000 || bus.data_1_en !== 1'b0) begin
      n_err++;
      $display("FAIL tim_resume: got led=%b en=%b, required 001000/0", bus.led, bus.data_1_en);
    end
    exp_q.push_back(16'h0055);
    tick();
    bus.t_valid = 1'b0;
    n_vec++;
    if (bus.data_1_en !== 1'b1 || bus.data_1 !== 16'h0055) begin
      n_err++;
      $display("FAIL tim_write: got en=%b d=%h, required 1/0055", bus.data_1_en, bus.data_1);
    end
    tick();
    go_idle();
  endtask

  task automatic test_both_start();
    bus.start_f_ed = 1'b1;
    bus.start_t_ed = 1'b1;
    tick();
    bus.start_f_ed = 1'b0;
    bus.start_t_ed = 1'b0;
    n_vec++;
    if (bus.led !== 6'b000010 || bus.modulo !== 2'b01) begin
      n_err++;
      $display("FAIL both_start: got led=%b mod=%b, required 000010/01", bus.led, bus.modulo);
    end
    start_run(1'b0);
    n_vec++;
    if (bus.led !== 6'b000010 || bus.modulo !== 2'b01 || bus.t_en !== 1'b0 || bus.f_en !== 1'b1) begin
      n_err++;
      $display("FAIL start_ignored: got led=%b mod=%b t_en=%b f_en=%b, required 000010/01/0/1",
               bus.led, bus.modulo, bus.t_en, bus.f_en);
    end
    go_idle();
  endtask

  task automatic test_stop_drop();
    start_run(1'b1);
    bus.f_valid     = 1'b1;
    bus.f_out       = 16'hBEEF;
    bus.stop_f_t_ed = 1'b1;
    tick();
    bus.f_valid     = 1'b0;
    bus.stop_f_t_ed = 1'b0;
    n_vec++;
    if (bus.led !== 6'b100000 || bus.data_1_en !== 1'b0 || bus.modulo !== 2'b01) begin
      n_err++;
      $display("FAIL stop_drop: got led=%b en=%b mod=%b, required 100000/0/01", bus.led, bus.data_1_en, bus.modulo);
    end
    bus.buffer_empty = 1'b1;
    tick();
    bus.buffer_empty = 1'b0;
    n_vec++;
    if (bus.led !== 6'b000001 || bus.modulo !== 2'b00 || bus.wr_count !== 16'd0) begin
      n_err++;
      $display("FAIL stop_idle: got led=%b mod=%b cnt=%0d, required 000001/00/0", bus.led, bus.modulo, bus.wr_count);
    end
  endtask

  task automatic test_drain_timeout();
    start_run(1'b1);
    bus.stop_f_t_ed = 1'b1;
    tick();
    bus.stop_f_t_ed = 1'b0;
    for (int k = 1; k < 8; k++) begin
      tick();
      n_vec++;
      if (bus.led !== 6'b100000 || bus.drain_err !== 1'b0) begin
        n_err++;
        $display("FAIL drain_wait%0d: got led=%b err=%b, required 100000/0", k, bus.led, bus.drain_err);
      end
    end
    tick();
    n_vec++;
    if (bus.led !== 6'b000001 || bus.drain_err !== 1'b1) begin
      n_err++;
      $display("FAIL drain_timeout: got led=%b err=%b, required 000001/1", bus.led, bus.drain_err);
    end
    tick();
    tick();
    n_vec++;
    if (bus.drain_err !== 1'b1) begin
      n_err++;
      $display("FAIL drain_sticky: got %b, required 1", bus.drain_err);
    end
    start_run(1'b1);
    n_vec++;
    if (bus.drain_err !== 1'b0 || bus.led !== 6'b000010) begin
      n_err++;
      $display("FAIL drain_clear: got err=%b led=%b, required 0/000010", bus.drain_err, bus.led);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    start_run(1'b1);
    bus.f_valid = 1'b1;
    bus.f_out   = 16'h0007;
    exp_q.push_back(16'h0007);
    tick();
    bus.f_valid     = 1'b0;
    bus.buffer_full = 1'b1;
    tick();
    n_vec++;
    if (bus.led !== 6'b000100 || bus.wr_count !== 16'd1) begin
      n_err++;
      $display("FAIL wait_f: got led=%b cnt=%0d, required 000100/1", bus.led, bus.wr_count);
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (bus.led !== 6'b000001 || bus.data_1_en !== 1'b0 || bus.wr_count !== 16'd0 ||
        bus.f_en !== 1'b0 || bus.modulo !== 2'b00) begin
      n_err++;
      $display("FAIL rst_wait: got led=%b en=%b cnt=%0d f_en=%b mod=%b, required 000001/0/0/0/00",
               bus.led, bus.data_1_en, bus.wr_count, bus.f_en, bus.modulo);
    end
    bus.buffer_full = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    // Write strobe in flight when reset hits: must vanish immediately
    start_run(1'b1);
    bus.f_valid = 1'b1;
    bus.f_out   = 16'h00AA;
    tick();
    bus.f_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.data_1_en !== 1'b0 || bus.data_1 !== 16'h0 || bus.led !== 6'b000001) begin
      n_err++;
      $display("FAIL rst_inflight: got en=%b d=%h led=%b, required 0/0000/000001", bus.data_1_en, bus.data_1, bus.led);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start_f_ed   = 1'b0;
    bus.start_t_ed   = 1'b0;
    bus.stop_f_t_ed  = 1'b0;
    bus.buffer_full  = 1'b0;
    bus.buffer_empty = 1'b0;
    bus.data_2_valid = 1'b0;
    bus.f_valid      = 1'b0;
    bus.f_out        = '0;
    bus.t_valid      = 1'b0;
    bus.t_out        = '0;

    test_reset();
    test_fib_run();
    test_throttle();
    test_both_start();
    test_stop_drop();
    test_drain_timeout();
    test_reset_mid();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d pending words, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
